// File: rtl/gate_tt_sequencer_pkg.sv
// Shared types and constants for the gate truth-table sequencer: FSM state
// encoding and golden truth tables for common 2-input gates.
package gate_tt_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  // Bit i is the gate output for input vector i ({b,a} = i).
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/tt_compare.sv
// Compares a captured truth table with the golden one and reports the lowest
// mismatching vector index.
module tt_compare #(
  parameter int N_IN  = 2,
  parameter int N_VEC = 1 << N_IN
) (
  input  logic [N_VEC-1:0] captured_i,
  input  logic [N_VEC-1:0] expected_i,
  output logic             pass_o,
  output logic [N_IN-1:0]  fail_idx_o
);

  logic [N_VEC-1:0] diff;

  assign diff   = captured_i ^ expected_i;
  assign pass_o = ~|diff;

  // Scanning downwards lets the lowest mismatching index overwrite the others.
  always_comb begin
    // NOTE: the default assignment comes first so every path drives the
    // output and no latch is inferred.
    fail_idx_o = '0;
    for (int i = N_VEC - 1; i >= 0; i--) begin
      if (diff[i]) fail_idx_o = N_IN'(i);
    end
  end

endmodule

// File: rtl/gate_tt_sequencer.sv
// Sweeps every input vector of a gate under test, holding each for HOLD_CYCLES
// clocks, captures the gate output and checks it against EXPECTED_TT.
module gate_tt_sequencer
  import gate_tt_sequencer_pkg::*;
#(
  parameter int                   N_IN        = 2,
  parameter int                   HOLD_CYCLES = 5,
  parameter logic [(1<<N_IN)-1:0] EXPECTED_TT = TT_AND2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic [N_IN-1:0]        gate_in,
  input  logic                   gate_y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN-1:0]        fail_idx,
  output logic [(1<<N_IN)-1:0]   captured_tt
);

  localparam int                N_VEC     = 1 << N_IN;
  localparam int                CNT_W     = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0]   VEC_LAST  = N_IN'(N_VEC - 1);

  state_e             state_q, state_d;
  logic [N_IN-1:0]    vec_q, vec_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [N_VEC-1:0]   tt_q, tt_d;
  logic [N_VEC-1:0]   tt_sampled;
  logic               pass_q, pass_d;
  logic [N_IN-1:0]    fail_idx_q, fail_idx_d;
  logic               cmp_pass;
  logic [N_IN-1:0]    cmp_fail_idx;

  // Table as it will look once the current vector is captured, so the verdict
  // taken on the final capture edge already includes the last vector.
  always_comb begin
    tt_sampled        = tt_q;
    tt_sampled[vec_q] = gate_y;
  end

  tt_compare #(
    .N_IN  (N_IN),
    .N_VEC (N_VEC)
  ) u_compare (
    .captured_i (tt_sampled),
    .expected_i (EXPECTED_TT),
    .pass_o     (cmp_pass),
    .fail_idx_o (cmp_fail_idx)
  );

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    hold_d     = hold_q;
    tt_d       = tt_q;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_DRIVE;
          vec_d      = '0;
          hold_d     = '0;
          tt_d       = '0;
          pass_d     = 1'b0;
          fail_idx_d = '0;
        end
      end

      ST_DRIVE: begin
        if (abort) begin
          // Partial table is kept for debug; the verdict stays at fail.
          state_d = ST_IDLE;
          vec_d   = '0;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          tt_d   = tt_sampled;
          hold_d = '0;
          if (vec_q == VEC_LAST) begin
            state_d    = ST_REPORT;
            pass_d     = cmp_pass;
            fail_idx_d = cmp_fail_idx;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      ST_REPORT: begin
        state_d = ST_IDLE;
        vec_d   = '0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      hold_q     <= '0;
      tt_q       <= '0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      vec_q      <= vec_d;
      hold_q     <= hold_d;
      tt_q       <= tt_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign gate_in     = vec_q;
  assign busy        = (state_q == ST_DRIVE);
  assign done        = (state_q == ST_REPORT);
  assign pass        = pass_q;
  assign fail_idx    = fail_idx_q;
  assign captured_tt = tt_q;

endmodule
